fetch_sequencer: RTL

Instruction-fetch controller that owns the program counter and sequences requests to instruction memory. It keeps at most one fetch in flight and applies branch/jump redirects with priority over sequential fetch, discarding any stale in-flight response. Fetched words go to decode through a one-entry valid/ready output register.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_out_buffer.sv | 49 ++++
 rtl/fetch_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and defaults for the instruction-fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Address and instruction words are both 32 bits wide.
  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  // Default PC after reset and default sequential increment in bytes.
  localparam addr_t RESET_PC_DEF = 32'h0000_0000;
  localparam addr_t PC_STEP_DEF  = 32'd4;

  // Fetch FSM: REQ may issue a request, WAIT holds one fetch in flight.
  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_buffer
// Brief    : One-entry valid/ready holding register between fetch and decode.
//            A flush wins over both a load and a pop in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_out_buffer
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  pop_i,
  input  logic  flush_i,
  input  addr_t pc_i,
  input  inst_t data_i,
  output logic  valid_o,
  output addr_t pc_o,
  output inst_t data_o
);

  logic  valid_q;
  addr_t pc_q;
  inst_t data_q;

  // Holding register: flush drops the entry, load captures, pop releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      data_q  <= data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;

endmodule : fetch_out_buffer
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Owns the PC, keeps at most one instruction fetch in flight,
//            applies redirects ahead of sequential fetch and drops any
//            response that a redirect has made stale.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter addr_t PC_STEP  = PC_STEP_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  halt,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  imem_req,
  output addr_t imem_addr,
  input  logic  imem_gnt,
  input  logic  imem_rvalid,
  input  inst_t imem_rdata,
  output logic  inst_valid,
  output addr_t inst_pc,
  output inst_t inst_data,
  input  logic  inst_ready
);

  state_e state_q, state_d;
  addr_t  pc_q, pc_d;
  addr_t  fetch_pc_q, fetch_pc_d;
  logic   kill_q, kill_d;

  logic   buf_free;
  logic   buf_load;
  logic   buf_pop;

  // A request may only go out when the single output slot is (or is about
  // to be) empty, so a returning response always has somewhere to land.
  // rst_n gates the request so memory never sees it during reset.
  assign buf_free  = !inst_valid || inst_ready;
  assign imem_req  = rst_n && (state_q == ST_REQ) && buf_free && !halt && !redirect_valid;
  assign imem_addr = pc_q;
  assign buf_pop   = inst_valid && inst_ready;

  // Next-state logic for the FSM, PC, in-flight PC and kill flag.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    buf_load   = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req && imem_gnt) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // A redirect arriving with the data still makes that data stale.
          if (kill_q || redirect_valid) begin
            kill_d = 1'b0;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else begin
            buf_load = 1'b1;
          end
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = redirect_pc;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // FSM and PC state registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  fetch_out_buffer u_out_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .pc_i    (fetch_pc_q),
    .data_i  (imem_rdata),
    .valid_o (inst_valid),
    .pc_o    (inst_pc),
    .data_o  (inst_data)
  );

endmodule : fetch_sequencer
`default_nettype wire
